// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer driving the output mux (parity state under UART_TX_PARITY_EN)
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_odd,
    output logic [1:0]           select,
    output logic                 data_bit,
    output logic                 parity_bit,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [IW-1:0]        idx, idx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [1:0]           select_next;
    logic                 data_bit_next;
    logic                 busy_next;
    logic                 done_next;
    logic                 at_end;

`ifdef UART_TX_PARITY_EN
    logic                 parity_next;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign parity_bit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            select     <= SEL_STOP;
            data_bit   <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            shreg      <= shreg_next;
            select     <= select_next;
            data_bit   <= data_bit_next;
            tx_busy    <= busy_next;
            tx_done    <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    // Counter clears on every state change so each bit is exactly CLKS_PER_BIT cycles.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        idx_next      = idx;
        shreg_next    = shreg;
        select_next   = select;
        data_bit_next = data_bit;
        busy_next     = tx_busy;
        done_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_bit;
`endif
        at_end        = (cnt == CNT_LAST);

        case (state)
            IDLE: begin
                select_next = SEL_STOP;
                busy_next   = 1'b0;
                cnt_next    = '0;
                idx_next    = '0;
                if (tx_start) begin
                    shreg_next    = tx_data;
                    data_bit_next = tx_data[0];
`ifdef UART_TX_PARITY_EN
                    parity_next   = parity_odd ? ~^tx_data : ^tx_data;
`endif
                    state_next    = START;
                    select_next   = SEL_START;
                    busy_next     = 1'b1;
                end
            end
            START: begin
                if (at_end) begin
                    state_next  = DATA;
                    select_next = SEL_DATA;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (at_end) begin
                    cnt_next      = '0;
                    shreg_next    = {1'b0, shreg[DATA_BITS-1:1]};
                    data_bit_next = shreg[1];
                    if (idx == IDX_LAST) begin
                        idx_next    = '0;
`ifdef UART_TX_PARITY_EN
                        state_next  = PARITY;
                        select_next = SEL_PARITY;
`else
                        state_next  = STOP;
                        select_next = SEL_STOP;
`endif
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (at_end) begin
                    state_next  = STOP;
                    select_next = SEL_STOP;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (at_end) begin
                    state_next  = IDLE;
                    select_next = SEL_STOP;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                select_next = SEL_STOP;
                busy_next   = 1'b0;
                cnt_next    = '0;
                idx_next    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl (either UART_TX_PARITY_EN build)
module tb_uart_tx_ctrl;

    localparam int CPB  = 4;
    localparam int DB   = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int PHASES = DB + 2 + (PAR_EN ? 1 : 0);
    localparam int FRAME  = PHASES * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_start;
    logic [DB-1:0] tx_data;
    logic          parity_odd;
    logic [1:0]    select;
    logic          data_bit;
    logic          parity_bit;
    logic          tx_busy;
    logic          tx_done;

    int tests = 0;
    int fails = 0;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .parity_odd (parity_odd),
        .select     (select),
        .data_bit   (data_bit),
        .parity_bit (parity_bit),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame from IDLE and checks every cycle; returns in the tx_done cycle.
    task automatic run_frame(input logic [7:0] d, input logic odd, input int repulse_at, input bit keep_start);
        logic       exp_par;
        logic [1:0] exp_sel;
        int         ph;
        exp_par    = PAR_EN ? (odd ? ~^d : ^d) : 1'b0;
        tx_data    = d;
        parity_odd = odd;
        tx_start   = 1'b1;
        step();
        if (!keep_start) tx_start = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            ph = i / CPB;
            if (ph == 0)                          exp_sel = 2'b00;
            else if (ph <= DB)                    exp_sel = 2'b01;
            else if (PAR_EN && ph == DB + 1)      exp_sel = 2'b10;
            else                                  exp_sel = 2'b11;
            chk($sformatf("sel[%0h,%0d]", d, i), {6'd0, select}, {6'd0, exp_sel});
            chk($sformatf("busy[%0h,%0d]", d, i), {7'd0, tx_busy}, 8'd1);
            chk($sformatf("done[%0h,%0d]", d, i), {7'd0, tx_done}, 8'd0);
            chk($sformatf("par[%0h,%0d]", d, i), {7'd0, parity_bit}, {7'd0, exp_par});
            if (exp_sel == 2'b01)
                chk($sformatf("dbit[%0h,%0d]", d, i), {7'd0, data_bit}, {7'd0, d[ph-1]});
            if (repulse_at >= 0) begin
                if (i == repulse_at) tx_start = 1'b1;
                else if (i == repulse_at + 1) tx_start = 1'b0;
            end
            step();
        end
        chk($sformatf("end_busy[%0h]", d), {7'd0, tx_busy}, 8'd0);
        chk($sformatf("end_done[%0h]", d), {7'd0, tx_done}, 8'd1);
        chk($sformatf("end_sel[%0h]", d), {6'd0, select}, 8'd3);
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s_sel[%0d]", tag, i), {6'd0, select}, 8'd3);
            chk($sformatf("%s_busy[%0d]", tag, i), {7'd0, tx_busy}, 8'd0);
            chk($sformatf("%s_done[%0d]", tag, i), {7'd0, tx_done}, 8'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        tx_start   = 1'b0;
        tx_data    = '0;
        parity_odd = 1'b0;
        step();
        step();
        chk("rst_sel", {6'd0, select}, 8'd3);
        chk("rst_dbit", {7'd0, data_bit}, 8'd0);
        chk("rst_par", {7'd0, parity_bit}, 8'd0);
        chk("rst_busy", {7'd0, tx_busy}, 8'd0);
        chk("rst_done", {7'd0, tx_done}, 8'd0);
        rst_n = 1'b1;
        step();

        run_frame(8'hA5, 1'b0, -1, 1'b0);
        check_idle("after_a5e", 2);
        run_frame(8'hA5, 1'b1, -1, 1'b0);
        check_idle("after_a5o", 2);
        run_frame(8'h00, 1'b0, -1, 1'b0);
        check_idle("after_00", 2);

        run_frame(8'hA5, 1'b0, 10, 1'b0);
        check_idle("after_repulse", 2 * CPB);

        run_frame(8'h3C, 1'b0, -1, 1'b1);
        run_frame(8'hC3, 1'b0, -1, 1'b1);
        tx_start = 1'b0;
        check_idle("after_held", 4);

        tx_data    = 8'hA5;
        parity_odd = 1'b0;
        tx_start   = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (CPB * 4 + 1) step();
        chk("pre_rst_sel", {6'd0, select}, 8'd1);
        chk("pre_rst_dbit", {7'd0, data_bit}, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", {6'd0, select}, 8'd3);
        chk("mid_rst_busy", {7'd0, tx_busy}, 8'd0);
        chk("mid_rst_done", {7'd0, tx_done}, 8'd0);
        chk("mid_rst_par", {7'd0, parity_bit}, 8'd0);
        step();
        rst_n = 1'b1;
        check_idle("post_rst", 3);
        run_frame(8'h55, 1'b0, -1, 1'b0);
        check_idle("after_55", 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side sequencer for the UART. It accepts a parallel byte with a one-cycle start strobe and generates the baud-timed frame sequence: start, 8 data bits LSB-first, optional parity, stop. It drives the `select`, `data_bit` and `parity_bit` inputs of the downstream transmit output mux, which turns them into the serial line level.

## Interface

- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥2.
- `DATA_BITS`, default 8: payload width; legal range 5–8.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_start`  in  1  one-cycle request; sampled only in IDLE.
- `tx_data`  in  DATA_BITS  payload; captured on the accepting edge.
- `parity_odd`  in  1  parity type, captured with `tx_data`: 1 = odd, 0 = even.
- `select`  out  2  mux select: 00 start, 01 data, 10 parity, 11 stop/idle.
- `data_bit`  out  1  current data bit, equal to shift register bit 0.
- `parity_bit`  out  1  registered parity of the captured byte.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse after the stop bit completes.

## Operation

- FSM states are IDLE, START, DATA, PARITY and STOP. Every output is registered.
- Reset values: state IDLE, `select`=2'b11, `data_bit`=0, `parity_bit`=0, `tx_busy`=0, `tx_done`=0, baud counter 0, bit index 0.
- IDLE: `select`=11, so the line idles high.
  - When `tx_start`=1, the block loads `tx_data` into the shift register.
  - `parity_bit` is set to `^tx_data` (even) or `~^tx_data` (odd).
  - The next state is START.
- START: `select`=00 for CLKS_PER_BIT cycles, then DATA.
- DATA: `select`=01.
  - After each CLKS_PER_BIT cycles, the shift register shifts right by one and the bit index increments.
  - After DATA_BITS bits, the next state is PARITY (or STOP, see Configuration).
- PARITY: `select`=10 for CLKS_PER_BIT cycles, then STOP.
- STOP: `select`=11 for CLKS_PER_BIT cycles, then IDLE.
  - `tx_done` pulses in the first IDLE cycle.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change. The bit boundary is the terminal count.
- `tx_start` is ignored outside IDLE. It has no queueing and no error flag.
- `tx_data` and `parity_odd` are don't-care except on the accepting edge.

## Timing

- `tx_start` is sampled high at edge k. From cycle k+1:
  - `select`=00 and `tx_busy`=1.
  - The first data bit appears at k+1+CLKS_PER_BIT.
- Each bit lasts exactly CLKS_PER_BIT cycles. There is no jitter and no extra cycle between bits.
- Frame length:
  - (DATA_BITS+3)·CLKS_PER_BIT cycles with parity.
  - (DATA_BITS+2)·CLKS_PER_BIT cycles without parity.
- `tx_busy` deasserts in the same cycle `tx_done` asserts.
- Back-to-back: a `tx_start` in the `tx_done` cycle is accepted. The next START begins the following cycle, so there is exactly one idle-high cycle between frames.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately, asynchronously.
  - `select`=11, so the line goes high.
  - No `tx_done` pulse is produced. The partial frame is abandoned.
- `data_bit` holds its last shifted value outside DATA. The mux ignores it there.

## Configuration

- Macro `UART_TX_PARITY_EN`.
- Defined: the PARITY state exists and `parity_bit` is computed as above.
- Undefined:
  - The PARITY state is not compiled, and DATA goes directly to STOP.
  - `parity_bit` is tied 0.
  - `parity_odd` is unused.
  - `select` never takes the value 10.

## Test plan

- Parity enabled, CLKS_PER_BIT=4, `tx_data`=8'hA5, even parity:
  - `select` runs 00×4, then 01×32 with `data_bit` = 1,0,1,0,0,1,0,1 (4 cycles each), then 10×4 with `parity_bit`=0, then 11×4.
  - `tx_busy` is high for exactly 44 cycles, followed by a single `tx_done` pulse.
- Same byte with `parity_odd`=1: `parity_bit`=1 during `select`=10. With 8'h00 even parity: `parity_bit`=0.
- `tx_start` re-pulsed at cycle 10 of a frame: the frame is unchanged, still 44 cycles, and no second frame follows.
- `tx_start` held high continuously with 8'h3C then 8'hC3:
  - Two frames run with exactly one `select`=11 cycle between them.
  - `tx_done` pulses once per frame.
- `rst_n` dropped during DATA bit 3:
  - Within the same cycle, `select`=11, `tx_busy`=0, and no `tx_done` pulse.
  - After release, a new 8'h55 frame transmits correctly.
- Macro undefined, CLKS_PER_BIT=4, 8'hA5: `select` never equals 10, and the frame is 40 cycles.
